ram_arbiter: RTL
================

# ram_arbiter

Round-robin arbiter that shares one single-port-pair RAM (write port plus read port, `read_valid`-flagged read return) between `NUM_REQ` requesters. Each requester issues one read or write per valid/ready handshake. The block drives the RAM-side signals from registers and routes each returning read word back to the requester that issued it. It sits between client engines and the RAM instance, on the DUT side of the RAM interface.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8
- `D_WIDTH`, 32: data width
- `A_WIDTH`, 5: address width
- `RD_LAT`, 1: RAM cycles from `read_en` to `read_valid`, 1..4

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in NUM_REQ: requester i has an operation pending
- `req_we` in NUM_REQ: 1 = write, 0 = read, per requester
- `req_addr` in NUM_REQ*A_WIDTH: packed addresses, requester i at [i*A_WIDTH +: A_WIDTH]
- `req_wdata` in NUM_REQ*D_WIDTH: packed write data, same packing
- `req_ready` out NUM_REQ: one-hot grant; a handshake occurs when `req_valid[i] & req_ready[i]`
- `rsp_valid` out NUM_REQ: one-hot, read data returned to requester i
- `rsp_data` out D_WIDTH: shared read return data
- `write_data` out D_WIDTH, `write_addr` out A_WIDTH, `write_en` out 1: RAM write port
- `read_addr` out A_WIDTH, `read_en` out 1: RAM read port
- `read_data` in D_WIDTH, `read_valid` in 1: RAM read return
- `err` out 1: sticky protocol error

## Operation
- Grant selection:
  - Each cycle, the first `req_valid` at or after pointer `ptr`, in cyclic order, receives `req_ready`.
  - `req_ready` is combinational from `req_valid` and `ptr`, and is at most one-hot.
  - No valid request gives all-zero `req_ready`.
- Pointer update:
  - On a handshake by requester g, `ptr` becomes (g+1) mod NUM_REQ.
  - With no handshake, `ptr` holds.
- Issue register:
  - A granted write loads `write_en=1`, `write_addr`, `write_data` next cycle.
  - A granted read loads `read_en=1`, `read_addr` next cycle.
  - The other enable is 0. Enables are 1-cycle pulses, so at most one RAM op is issued per cycle.
  - Address and data registers hold their last value when idle.
- Tag pipeline:
  - A shift register of depth 1+RD_LAT carries {valid, requester index} for each read.
  - The entry is loaded at the read grant and reaches the head in the cycle `read_valid` is due.
- Response:
  - When the head tag is valid and `read_valid=1`, next cycle `rsp_valid[idx]=1` and `rsp_data` = captured `read_data`.
  - `rsp_data` holds between responses.
- Error:
  - `err` sets if `read_valid=1` with an invalid head tag, or if the head tag is valid and `read_valid=0`.
  - `err` clears only on `rst`.
  - On a missing `read_valid`, the response is dropped (no `rsp_valid`).
- Simultaneous events: a grant, a RAM issue, and a response can all occur in the same cycle; they are independent.
- Reset values (`rst`=1, including mid-operation):
  - `ptr`=0; tag pipeline cleared, so in-flight reads are discarded.
  - `write_en`, `read_en`, `rsp_valid`, `err` = 0.
  - `write_data`, `write_addr`, `read_addr`, `rsp_data` = 0.
  - `req_ready`=0 while `rst`=1.

## Timing
- Write: handshake at cycle T → `write_en` at T+1.
- Read:
  - handshake at T → `read_en` at T+1
  - `read_valid` expected at T+1+RD_LAT
  - `rsp_valid` at T+2+RD_LAT
- Throughput: one operation per cycle, sustained. Back-to-back reads from different requesters return in issue order.
- A requester that keeps `req_valid` asserted is re-granted only after every other active requester has been served once.

## Structure
- Package `ram_arb_pkg`:
  - `MAX_REQ`=8, `MAX_RD_LAT`=4
  - typedef `req_idx_t` (logic [2:0])
  - typedef `rd_tag_t` (struct {valid, req_idx_t idx})
- Sub-module `rr_arbiter`: combinational one-hot grant from `req_valid` and `ptr`, plus the `ptr` register. It is parameterised on `NUM_REQ` and reused by other shared-resource blocks.
- Top level contains the issue registers, tag pipeline, response register and error flag.

## Test plan
- Reset then idle, all `req_valid`=0 → `req_ready`=0, no enables, `err`=0, all outputs 0.
- Requester 2 writes addr 5 / 0xDEADBEEF at T, then reads addr 5 → `write_en` at T+1 with those values; `rsp_valid[2]` with `rsp_data`=0xDEADBEEF at read handshake +2+RD_LAT.
- All four requesters hold `req_valid`=1 for 8 cycles starting from `ptr`=0 → grants 0,1,2,3,0,1,2,3, one per cycle.
- Requesters 1 and 3 read addr 7 and addr 9 back-to-back (RD_LAT=1 and RD_LAT=3) → `rsp_valid[1]` then `rsp_valid[3]` on consecutive cycles, each with its own data.
- Reset asserted 1 cycle after a read issue → no `rsp_valid`, `err` stays 0, `ptr`=0.
- RAM model drives a spurious `read_valid` with no read pending, or suppresses an expected one → `err`=1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter and its round-robin grant logic.
package ram_arb_pkg;

    localparam int MAX_REQ    = 8;
    localparam int MAX_RD_LAT = 4;

    typedef logic [2:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rd_tag_t;

    // Pointer value that follows a grant to requester g among n requesters.
    function automatic req_idx_t rr_next(input req_idx_t g, input int n);
        return (int'(g) == n - 1) ? 3'd0 : g + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after
// the pointer, which then moves just past the granted requester.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_idx
);

    req_idx_t ptr_q;
    req_idx_t ptr_d;
    int       best_s;
    int       sel_s;
    int       dist_s;
    logic     found_s;

    // Pick the valid requester with the smallest cyclic distance from ptr.
    always_comb begin
        best_s  = NUM_REQ;
        sel_s   = 0;
        dist_s  = 0;
        grant   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = i - int'(ptr_q);
            dist_s = (dist_s < 0) ? dist_s + NUM_REQ : dist_s;
            if (req_valid[i] && (dist_s < best_s)) begin
                best_s = dist_s;
                sel_s  = i;
            end else begin
                best_s = best_s;
            end
        end
        found_s = (best_s < NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = found_s && (sel_s == i);
        end
        grant_idx = 3'(sel_s);
        ptr_d     = found_s ? rr_next(3'(sel_s), NUM_REQ) : ptr_q;
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one write/read RAM port pair between NUM_REQ requesters and routes
// each read return back to the requester that issued it.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int RD_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*D_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [D_WIDTH-1:0]         rsp_data,
    output logic [D_WIDTH-1:0]         write_data,
    output logic [A_WIDTH-1:0]         write_addr,
    output logic                       write_en,
    output logic [A_WIDTH-1:0]         read_addr,
    output logic                       read_en,
    input  logic [D_WIDTH-1:0]         read_data,
    input  logic                       read_valid,
    output logic                       err
);

    logic [NUM_REQ-1:0] valid_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [2:0]         grant_idx_s;
    logic               hs_s;
    logic               sel_we_s;
    logic [A_WIDTH-1:0] sel_addr_s;
    logic [D_WIDTH-1:0] sel_wdata_s;
    rd_tag_t            new_tag_s;
    rd_tag_t            head_s;
    logic               rsp_hit_s;

    logic               write_en_q, write_en_d;
    logic               read_en_q, read_en_d;
    logic [A_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [D_WIDTH-1:0] write_data_q, write_data_d;
    logic [A_WIDTH-1:0] read_addr_q, read_addr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [D_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic               err_q, err_d;
    rd_tag_t            tag_q [0:RD_LAT];

    // Masking valids during reset keeps req_ready low while rst is high.
    assign valid_s = rst ? '0 : req_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_valid (valid_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Next-state for issue, tag, response and error registers.
    always_comb begin
        hs_s        = |grant_s;
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_we_s    = sel_we_s | (grant_s[i] & req_we[i]);
            sel_addr_s  = sel_addr_s | ({A_WIDTH{grant_s[i]}} & req_addr[i*A_WIDTH +: A_WIDTH]);
            sel_wdata_s = sel_wdata_s | ({D_WIDTH{grant_s[i]}} & req_wdata[i*D_WIDTH +: D_WIDTH]);
        end
        write_en_d      = hs_s & sel_we_s;
        read_en_d       = hs_s & ~sel_we_s;
        write_addr_d    = write_en_d ? sel_addr_s : write_addr_q;
        write_data_d    = write_en_d ? sel_wdata_s : write_data_q;
        read_addr_d     = read_en_d ? sel_addr_s : read_addr_q;
        new_tag_s.valid = read_en_d;
        new_tag_s.idx   = grant_idx_s;

        head_s      = tag_q[RD_LAT];
        rsp_hit_s   = head_s.valid & read_valid;
        rsp_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = rsp_hit_s & (head_s.idx == 3'(i));
        end
        rsp_data_d = rsp_hit_s ? read_data : rsp_data_q;
        err_d      = err_q | (head_s.valid ^ read_valid);
    end

    // State registers; the tag shift reaches its head when read_valid is due.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            read_addr_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            write_en_q   <= write_en_d;
            read_en_q    <= read_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            read_addr_q  <= read_addr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            err_q        <= err_d;
            tag_q[0]     <= new_tag_s;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign req_ready  = grant_s;
    assign write_en   = write_en_q;
    assign read_en    = read_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign read_addr  = read_addr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign err        = err_q;

endmodule
